// File: rtl/w_im2col.sv
// Weight-side im2col: streams K*K weight words from SRAM into one filter vector per beat,
// FILTER_COUNT filters per group, gated by the slice buffer-delete handshake. Option: W_ZERO_CNT_EN.
module w_im2col #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int FILTER_COUNT = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sudo_reset,
    input  logic                     conv_en,
    input  logic [2:0]               kernel,
    input  logic [ADDR_WIDTH-1:0]    w_base_addr,
    input  logic [7:0]               group_total,
    output logic                     w_rd_en,
    output logic [ADDR_WIDTH-1:0]    w_rd_addr,
    input  logic [DATA_WIDTH-1:0]    w_rd_data,
    output logic                     we_im2col_valid,
    output logic [DATA_WIDTH*9-1:0]  we3_im2col_data,
    output logic [DATA_WIDTH*36-1:0] we6_im2col_data,
    input  logic                     we_valid_del,
    output logic                     group_done,
    output logic                     all_done
`ifdef W_ZERO_CNT_EN
    ,
    output logic [9:0]               w_zero_cnt
`endif
);
    localparam int K3_W  = DATA_WIDTH * 9;
    localparam int ASM_W = DATA_WIDTH * 36;
    localparam int FW    = $clog2(FILTER_COUNT + 1);

    typedef enum logic [2:0] {IDLE, DECIDE, FETCH, CAPTURE, EMIT, WAIT_DEL, DONE} state_t;
    state_t state, state_nx;

    logic [2:0]            kern_q;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [5:0]            word_cnt, word_last, rd_idx;
    logic [FW-1:0]         filt_cnt;
    logic [7:0]            grp_cnt, grp_lim;
    logic                  rd_vld, k6, k_ok, filt_last;
    logic [ASM_W-1:0]      asm_q, asm_nx;

    // Kernel is latched in IDLE so mid-run changes cannot disturb a group.
    assign k6        = (kern_q == 3'd6);
    assign k_ok      = (kern_q == 3'd3) || k6;
    assign word_last = k6 ? 6'd35 : 6'd8;
    assign filt_last = (filt_cnt == FW'(FILTER_COUNT - 1));

    assign w_rd_en         = (state == FETCH);
    assign w_rd_addr       = w_rd_en ? addr_cnt : '0;
    assign we_im2col_valid = (state == EMIT);
    assign group_done      = (state == EMIT) && filt_last;
    assign all_done        = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (conv_en) state_nx = DECIDE;
            DECIDE:   if (k_ok) state_nx = FETCH;
            FETCH:    if (word_cnt == word_last) state_nx = CAPTURE;
            CAPTURE:  state_nx = EMIT;
            EMIT:     state_nx = filt_last ? WAIT_DEL : FETCH;
            WAIT_DEL: if (we_valid_del) state_nx = (grp_cnt + 8'd1 == grp_lim) ? DONE : FETCH;
            DONE:     if (!conv_en) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        if (sudo_reset) state_nx = IDLE;
    end

    // Read data lands one cycle after the strobe; merge it so CAPTURE can publish the full vector.
    always_comb begin
        asm_nx = asm_q;
        if (rd_vld) asm_nx[int'(rd_idx)*DATA_WIDTH +: DATA_WIDTH] = w_rd_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;        kern_q <= '0;   addr_cnt <= '0; word_cnt <= '0;
            filt_cnt <= '0;       grp_cnt <= '0;  grp_lim <= '0;  rd_vld <= 1'b0;
            rd_idx <= '0;         asm_q <= '0;
            we3_im2col_data <= '0; we6_im2col_data <= '0;
        end else if (sudo_reset) begin
            state <= IDLE;        kern_q <= '0;   addr_cnt <= '0; word_cnt <= '0;
            filt_cnt <= '0;       grp_cnt <= '0;  grp_lim <= '0;  rd_vld <= 1'b0;
            rd_idx <= '0;         asm_q <= '0;
            we3_im2col_data <= '0; we6_im2col_data <= '0;
        end else begin
            state  <= state_nx;
            rd_vld <= (state == FETCH);
            rd_idx <= word_cnt;
            asm_q  <= asm_nx;
            case (state)
                IDLE: begin
                    addr_cnt <= w_base_addr;
                    grp_lim  <= (group_total == 8'd0) ? 8'd1 : group_total;
                    kern_q   <= kernel;
                    grp_cnt  <= '0;
                    filt_cnt <= '0;
                    word_cnt <= '0;
                end
                FETCH: begin
                    addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
                    word_cnt <= (word_cnt == word_last) ? 6'd0 : word_cnt + 6'd1;
                end
                CAPTURE: begin
                    we3_im2col_data <= asm_nx[K3_W-1:0];
                    we6_im2col_data <= k6 ? asm_nx : {{(ASM_W-K3_W){1'b0}}, asm_nx[K3_W-1:0]};
                end
                EMIT:     filt_cnt <= filt_last ? '0 : filt_cnt + FW'(1);
                WAIT_DEL: if (we_valid_del) grp_cnt <= grp_cnt + 8'd1;
                default: ;
            endcase
        end
    end

`ifdef W_ZERO_CNT_EN
    // Per-group zero-word tally; restarts whenever a new group begins fetching.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            w_zero_cnt <= '0;
        else if (sudo_reset)
            w_zero_cnt <= '0;
        else if (state_nx == FETCH && (state == WAIT_DEL || state == DECIDE))
            w_zero_cnt <= '0;
        else if (rd_vld && w_rd_data == '0)
            w_zero_cnt <= w_zero_cnt + 10'd1;
    end
`endif
endmodule

// File: tb/tb_w_im2col.sv
// Randomized self-checking bench for w_im2col against an address/data reference model.
module tb_w_im2col;
    localparam int DW = 16;
    localparam int AW = 16;

    logic           clk = 1'b0, reset = 1'b0, sudo_reset = 1'b0, conv_en = 1'b0, we_valid_del = 1'b0;
    logic [2:0]     kernel = 3'd3;
    logic [AW-1:0]  w_base_addr = '0;
    logic [7:0]     group_total = 8'd1;
    logic           w_rd_en;
    logic [AW-1:0]  w_rd_addr;
    logic [DW-1:0]  w_rd_data = '0;
    logic           we_im2col_valid, group_done, all_done;
    logic [DW*9-1:0]  we3;
    logic [DW*36-1:0] we6;
`ifdef W_ZERO_CNT_EN
    logic [9:0]     w_zero_cnt;
`endif

    w_im2col dut (
        .clk(clk), .reset(reset), .sudo_reset(sudo_reset), .conv_en(conv_en), .kernel(kernel),
        .w_base_addr(w_base_addr), .group_total(group_total), .w_rd_en(w_rd_en),
        .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data), .we_im2col_valid(we_im2col_valid),
        .we3_im2col_data(we3), .we6_im2col_data(we6), .we_valid_del(we_valid_del),
        .group_done(group_done), .all_done(all_done)
`ifdef W_ZERO_CNT_EN
        , .w_zero_cnt(w_zero_cnt)
`endif
    );

    int checks = 0, passes = 0, cyc = 0, mode = 0, gd_alone = 0;
    logic [15:0] seed = '0;
    logic [AW-1:0]    rd_q[$];
    int               v_cyc[$];
    logic [DW*9-1:0]  v3_q[$];
    logic [DW*36-1:0] v6_q[$];
    bit               gd_q[$];
    int               zc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM contents as a function of address; mode picks the pattern.
    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        case (mode)
            0:       return a;
            1:       return (a * 16'h9E37) ^ seed;
            default: return a[0] ? a : 16'h0000;
        endcase
    endfunction

    // Filter n of a run starting at base: word j comes from base + n*K*K + j (mod 2^16).
    function automatic logic [DW*36-1:0] exp_vec(input logic [AW-1:0] base, input int k, input int n);
        logic [DW*36-1:0] v = '0;
        for (int j = 0; j < k*k; j++) v[j*DW +: DW] = mem(base + AW'(n*k*k + j));
        return v;
    endfunction

    always @(posedge clk) w_rd_data <= w_rd_en ? mem(w_rd_addr) : 16'($urandom);

    always @(negedge clk) begin
        if (w_rd_en) rd_q.push_back(w_rd_addr);
        if (we_im2col_valid) begin
            v_cyc.push_back(cyc); v3_q.push_back(we3); v6_q.push_back(we6); gd_q.push_back(group_done);
        end
        if (group_done && !we_im2col_valid) gd_alone++;
`ifdef W_ZERO_CNT_EN
        if (group_done) zc_q.push_back(int'(w_zero_cnt));
`endif
    end

    task automatic clear_mon;
        rd_q.delete(); v_cyc.delete(); v3_q.delete(); v6_q.delete(); gd_q.delete(); zc_q.delete();
    endtask

    task automatic wait_vld(input int n, input int budget, output bit ok);
        int t = 0;
        ok = 1'b1;
        while (v_cyc.size() < n) begin
            @(negedge clk); t++;
            if (t > budget) begin ok = 1'b0; break; end
        end
        @(negedge clk);
    endtask

    task automatic pulse_del;
        we_valid_del = 1'b1; @(negedge clk); we_valid_del = 1'b0;
    endtask

    function automatic int count_gd();
        int c = 0;
        foreach (gd_q[i]) if (gd_q[i]) c++;
        return c;
    endfunction

    function automatic int vec_errs(input logic [AW-1:0] base, input int k, input int n0);
        int e = 0;
        for (int i = 0; i < v3_q.size(); i++) begin
            logic [DW*36-1:0] v = exp_vec(base, k, n0 + i);
            if (v3_q[i] !== v[DW*9-1:0] || v6_q[i] !== v) e++;
        end
        return e;
    endfunction

    function automatic int seq_errs(input logic [AW-1:0] base);
        int e = 0;
        foreach (rd_q[i]) if (rd_q[i] !== base + AW'(i)) e++;
        return e;
    endfunction

    task automatic test_reset;
        reset = 1'b0; repeat (3) @(negedge clk);
        checks++; if ({w_rd_en, w_rd_addr, we_im2col_valid, group_done, all_done} !== '0)
            $display("FAIL reset_ctrl: got %0h exp 0", {w_rd_en, w_rd_addr, we_im2col_valid, group_done, all_done}); else passes++;
        checks++; if (we3 !== '0 || we6 !== '0) $display("FAIL reset_data: nonzero data got %0h", we3); else passes++;
        reset = 1'b1; repeat (2) @(negedge clk);
        checks++; if (w_rd_en !== 1'b0 || all_done !== 1'b0) $display("FAIL idle_quiet: rd_en %0b all_done %0b exp 0", w_rd_en, all_done); else passes++;
    endtask

    task automatic test_k3_basic;
        bit ok; int bad = 0;
        clear_mon(); mode = 0; kernel = 3'd3; w_base_addr = 16'h0100; group_total = 8'd1; conv_en = 1'b1;
        wait_vld(10, 400, ok);
        repeat (5) @(negedge clk);
        checks++; if (!ok || v_cyc.size() != 10) $display("FAIL k3_count: got %0d exp 10", v_cyc.size()); else passes++;
        for (int i = 1; i < v_cyc.size(); i++) if (v_cyc[i] - v_cyc[i-1] != 11) bad++;
        checks++; if (bad != 0) $display("FAIL k3_period: %0d gaps not 11", bad); else passes++;
        checks++; if (v3_q.size() == 0 || v3_q[0][15:0] !== 16'h0100 || v3_q[0][143:128] !== 16'h0108)
            $display("FAIL k3_first_words: got %0h exp 0108..0100", v3_q.size() ? v3_q[0] : '0); else passes++;
        checks++; if (vec_errs(16'h0100, 3, 0) != 0) $display("FAIL k3_vectors: %0d bad got nonzero exp 0", vec_errs(16'h0100, 3, 0)); else passes++;
        checks++; if (count_gd() != 1 || gd_q.size() != 10 || !gd_q[9] || gd_alone != 0)
            $display("FAIL k3_group_done: got %0d pulses exp 1 on 10th", count_gd()); else passes++;
        checks++; if (rd_q.size() != 90 || rd_q[89] !== 16'h0159 || seq_errs(16'h0100) != 0)
            $display("FAIL k3_addr: got %0d reads last %0h exp 90 / 0159", rd_q.size(), rd_q.size() ? rd_q[rd_q.size()-1] : '0); else passes++;
        checks++; if (all_done !== 1'b0) $display("FAIL k3_wait_del: all_done got %0b exp 0", all_done); else passes++;
        pulse_del();
        checks++; if (all_done !== 1'b1) $display("FAIL k3_all_done: got %0b exp 1", all_done); else passes++;
        conv_en = 1'b0; repeat (3) @(negedge clk);
        checks++; if (all_done !== 1'b0) $display("FAIL k3_back_idle: all_done got %0b exp 0", all_done); else passes++;
    endtask

    task automatic test_k6_random;
        bit ok1, ok2; logic [AW-1:0] base;
        clear_mon(); mode = 1; seed = 16'($urandom); base = 16'($urandom);
        kernel = 3'd6; w_base_addr = base; group_total = 8'd2; conv_en = 1'b1;
        wait_vld(10, 1000, ok1);
        kernel = 3'd3; conv_en = 1'b0;
        repeat (60) @(negedge clk);
        checks++; if (!ok1 || v_cyc.size() != 10 || all_done !== 1'b0)
            $display("FAIL k6_group_hold: got %0d filters exp 10", v_cyc.size()); else passes++;
        pulse_del();
        wait_vld(20, 1000, ok2);
        repeat (3) @(negedge clk);
        checks++; if (!ok2 || v_cyc.size() != 20) $display("FAIL k6_count: got %0d exp 20", v_cyc.size()); else passes++;
        checks++; if (rd_q.size() != 720 || rd_q[360] !== base + 16'd360 || seq_errs(base) != 0)
            $display("FAIL k6_addr: got %0d reads exp 720 from %0h", rd_q.size(), base); else passes++;
        checks++; if (vec_errs(base, 6, 0) != 0) $display("FAIL k6_vectors: %0d bad exp 0", vec_errs(base, 6, 0)); else passes++;
        checks++; if (count_gd() != 2 || !gd_q[9] || !gd_q[19]) $display("FAIL k6_group_done: got %0d exp 2", count_gd()); else passes++;
        pulse_del();
        checks++; if (all_done !== 1'b1) $display("FAIL k6_all_done: got %0b exp 1", all_done); else passes++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_bad_kernel;
        clear_mon(); kernel = 3'd1; conv_en = 1'b1;
        repeat (50) @(negedge clk);
        checks++; if (rd_q.size() != 0 || v_cyc.size() != 0 || all_done !== 1'b0)
            $display("FAIL bad_kernel: got %0d reads %0d valids exp 0", rd_q.size(), v_cyc.size()); else passes++;
        sudo_reset = 1'b1; conv_en = 1'b0; @(negedge clk); sudo_reset = 1'b0; kernel = 3'd3;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sudo_reset;
        bit ok; int n = 0, t = 0; logic [AW-1:0] nb = 16'hFFFA;
        clear_mon(); mode = 1; seed = 16'($urandom); kernel = 3'd3; w_base_addr = 16'($urandom);
        group_total = 8'd1; conv_en = 1'b1;
        while (n < 32 && t < 1000) begin @(negedge clk); t++; if (w_rd_en) n++; end
        checks++; if (n != 32) $display("FAIL sudo_reach: got %0d reads exp 32", n); else passes++;
        sudo_reset = 1'b1; w_base_addr = nb; @(negedge clk);
        checks++; if ({w_rd_en, w_rd_addr, we_im2col_valid, group_done, all_done} !== '0 || we3 !== '0 || we6 !== '0)
            $display("FAIL sudo_clear: outputs got %0h exp 0", {w_rd_en, w_rd_addr, we_im2col_valid}); else passes++;
        checks++; if (v_cyc.size() != 3) $display("FAIL sudo_pre_count: got %0d exp 3", v_cyc.size()); else passes++;
        sudo_reset = 1'b0; clear_mon();
        wait_vld(10, 400, ok);
        checks++; if (!ok || rd_q.size() != 90 || rd_q[0] !== nb || seq_errs(nb) != 0)
            $display("FAIL sudo_restart_addr: got first %0h exp %0h", rd_q.size() ? rd_q[0] : '0, nb); else passes++;
        checks++; if (vec_errs(nb, 3, 0) != 0) $display("FAIL sudo_restart_vec: %0d bad exp 0", vec_errs(nb, 3, 0)); else passes++;
        conv_en = 1'b0; pulse_del(); repeat (3) @(negedge clk);
    endtask

    task automatic test_del_ignored;
        bit ok; logic [AW-1:0] base = 16'($urandom);
        clear_mon(); mode = 0; kernel = 3'd3; w_base_addr = base; group_total = 8'd0; conv_en = 1'b1;
        wait_vld(4, 400, ok);
        repeat (3) @(negedge clk);
        pulse_del(); conv_en = 1'b0;
        wait_vld(10, 400, ok);
        repeat (60) @(negedge clk);
        checks++; if (!ok || v_cyc.size() != 10 || count_gd() != 1 || all_done !== 1'b0)
            $display("FAIL del_ignored: got %0d filters all_done %0b exp 10 / 0", v_cyc.size(), all_done); else passes++;
        pulse_del();
        checks++; if (all_done !== 1'b1) $display("FAIL group_zero_as_one: all_done got %0b exp 1", all_done); else passes++;
        repeat (3) @(negedge clk);
    endtask

`ifdef W_ZERO_CNT_EN
    task automatic test_zero_cnt;
        bit ok; int ez = 0;
        clear_mon(); mode = 2; kernel = 3'd3; w_base_addr = 16'h0100; group_total = 8'd1; conv_en = 1'b1;
        for (int i = 0; i < 90; i++) if (mem(16'h0100 + 16'(i)) == 16'h0000) ez++;
        wait_vld(10, 400, ok);
        repeat (5) @(negedge clk);
        checks++; if (!ok || zc_q.size() != 1 || zc_q[0] != ez) $display("FAIL zero_cnt: got %0d exp %0d", zc_q.size() ? zc_q[0] : -1, ez); else passes++;
        checks++; if (int'(w_zero_cnt) != ez) $display("FAIL zero_cnt_hold: got %0d exp %0d", w_zero_cnt, ez); else passes++;
        conv_en = 1'b0; pulse_del(); repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_k3_basic();
        test_k6_random();
        test_bad_kernel();
        test_sudo_reset();
        test_del_ignored();
`ifdef W_ZERO_CNT_EN
        test_zero_cnt();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/w_im2col.md
Name: w_im2col

Overview:
- Weight-side im2col stage. Sits directly upstream of the weight slice buffer.
- Reads filter weights one word per cycle from the external weight SRAM and assembles one K×K filter vector per output beat.
- Emits FILTER_COUNT filters per group, then waits for the slice's buffer-delete pulse before starting the next group.

Parameters:
- DATA_WIDTH, 16, width of one weight word.
- ADDR_WIDTH, 16, weight SRAM address width.
- FILTER_COUNT, 10, filters per group; matches the slice buffer depth.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- sudo_reset  in  1  synchronous soft clear, active high; overrides all other inputs.
- conv_en  in  1  run enable, level.
- kernel  in  3  kernel size: 3 or 6; any other value is unsupported.
- w_base_addr  in  ADDR_WIDTH  address of the first weight word; sampled in IDLE.
- group_total  in  8  number of groups to produce; sampled in IDLE; 0 is treated as 1.
- w_rd_en  out  1  SRAM read strobe.
- w_rd_addr  out  ADDR_WIDTH  SRAM read address.
- w_rd_data  in  DATA_WIDTH  SRAM read data; valid exactly 1 cycle after w_rd_en.
- we_im2col_valid  out  1  one-cycle pulse per assembled filter.
- we3_im2col_data  out  DATA_WIDTH*9  kernel-3 filter vector.
- we6_im2col_data  out  DATA_WIDTH*36  kernel-6 filter vector.
- we_valid_del  in  1  slice buffer consumed; releases the next group.
- group_done  out  1  one-cycle pulse when the last filter of a group is emitted.
- all_done  out  1  level; all groups emitted.

Behaviour:
- Reset (async) and sudo_reset (sync): state=IDLE; all outputs 0; all counters 0; assembly register 0.
- States:
  - IDLE: latch w_base_addr into the address counter and group_total into the group limit. Go to DECIDE when conv_en=1.
  - DECIDE: kernel=3 or kernel=6 → FETCH. Any other kernel value → stay in DECIDE; no reads are issued.
  - FETCH: assert w_rd_en for K*K consecutive cycles, with w_rd_addr incrementing by 1 each cycle. Word index j = 0..K*K-1.
  - CAPTURE: 1 cycle, absorbs the last read's data. Each returned word j is written into the assembly register at bits [j*DATA_WIDTH +: DATA_WIDTH].
  - EMIT: we_im2col_valid=1 for 1 cycle.
    - kernel=3: we3_im2col_data = assembly[143:0]; we6_im2col_data = {432'b0, assembly[143:0]}.
    - kernel=6: we6_im2col_data = assembly[575:0]; we3_im2col_data = assembly[143:0].
    - Data outputs hold their value until the next EMIT.
    - Filter counter increments. If the counter < FILTER_COUNT → FETCH. Otherwise pulse group_done in the same cycle, clear the filter counter, and go to WAIT_DEL.
  - WAIT_DEL: on we_valid_del=1, increment the group counter. If the group counter equals the group limit → DONE; otherwise → FETCH.
  - DONE: all_done=1. Go to IDLE when conv_en=0.
- Filter period is K*K+2 cycles: 11 cycles for K=3, 38 cycles for K=6. A K=3 group takes 110 cycles from FETCH entry to group_done.
- The address counter never rewinds within a run. Group g, filter f, word j reads address base + (g*FILTER_COUNT + f)*K*K + j, modulo 2^ADDR_WIDTH; wrap-around is silent.
- we_valid_del outside WAIT_DEL is ignored.
- kernel and conv_en changes mid-run are ignored until IDLE.
- Dropping conv_en mid-run does not abort; only sudo_reset or reset aborts.
- sudo_reset mid-FETCH: a pending read response on the next cycle is discarded.

Optional Feature:
- Macro: W_ZERO_CNT_EN.
- Defined:
  - Adds output w_zero_cnt (10 bits), the number of zero-valued words captured in the current group.
  - Cleared on reset, sudo_reset, and on entry to FETCH from WAIT_DEL or DECIDE.
  - Valid and stable from the group_done cycle until the next clear.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- K3, base=0x0100, group_total=1, SRAM data = address: 10 valid pulses, 11 cycles apart. First vector = {0x0108,…,0x0100} (word 0 in the LSBs). group_done coincides with the 10th valid. Last address read = 0x0159. Then raise we_valid_del → all_done=1.
- K6, base=0, group_total=2: 20 filters. Second group starts only after we_valid_del. Filter 10 word 0 is read from address 360. group_done pulses twice.
- kernel=1 with conv_en=1 for 50 cycles: state stays in DECIDE; w_rd_en never asserts; no valid pulses.
- sudo_reset asserted on FETCH cycle 4 of filter 3: next cycle all outputs are 0 and state is IDLE. Restart reads from the newly sampled base.
- we_valid_del pulsed mid-group: ignored. Exactly 10 filters are still emitted, and WAIT_DEL holds until a fresh we_valid_del.
- With W_ZERO_CNT_EN, K3 group whose words at even addresses are 0: w_zero_cnt=45 at group_done.
